booth_multiplier: RTL and testbench

Sequential radix-2 Booth multiplier for signed two's-complement operands. It computes P = A × M, one Booth recoding step per clock, and uses a start/done handshake. It is a standalone arithmetic block for datapaths that need a small, area-cheap signed multiply and can tolerate multi-cycle latency.

---
 rtl/booth_multiplier.sv | 114 +++++++++++
 tb/tb_booth_multiplier.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH, one recoding step per clock.
// state | meaning
// IDLE  | waiting for start; latches operands and clears ACC/Q_1
// RUN   | one Booth add/sub plus arithmetic shift per cycle, WIDTH cycles
// FIN   | registers the product and pulses done
module booth_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     M,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   P
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [WIDTH:0]       acc_q, acc_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic                 q1_q, q1_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic                 done_q, done_d;

   logic [WIDTH:0]       m_ext;
   logic [WIDTH:0]       sum;

   // ACC is one bit wider than M so that subtracting M = -2^(WIDTH-1) cannot overflow.
   always_comb begin
      m_ext = {m_q[WIDTH-1], m_q};
      case ({q_q[0], q1_q})
         2'b10:   sum = acc_q - m_ext;
         2'b01:   sum = acc_q + m_ext;
         default: sum = acc_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = M;
               q_d     = A;
               q1_d    = 1'b0;
               acc_d   = '0;
               cnt_d   = CNT_INIT;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = {sum[WIDTH], sum[WIDTH:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = FIN;
            end
         end
         FIN: begin
            p_d     = {acc_q[WIDTH-1:0], q_q};
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign P    = p_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: inputs driven on falling edges, outputs sampled 1 after rising edges.
module tb_booth_multiplier;

   localparam int W = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [W-1:0]     A;
   logic [W-1:0]     M;
   logic             busy;
   logic             done;
   logic [2*W-1:0]   P;

   int n_vec;
   int n_err;

   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] last_p;

   booth_multiplier #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .M     (M),
      .busy  (busy),
      .done  (done),
      .P     (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] m);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sm;
      int prod;
      sa = a;
      sm = m;
      prod = int'(sa) * int'(sm);
      return prod[2*W-1:0];
   endfunction

   // Monitor: reset values, scoreboard pop on done, P stability between done pulses.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         chk("rst_p", 32'(P), 32'(0));
         chk("rst_done", 32'(done), 32'(0));
         chk("rst_busy", 32'(busy), 32'(0));
         exp_q.delete();
         last_p = '0;
      end else if (done) begin
         chk("busy_at_done", 32'(busy), 32'(0));
         if (exp_q.size() == 0) begin
            chk("spurious_done", 32'(1), 32'(0));
         end else begin
            chk("product", 32'(P), 32'(exp_q.pop_front()));
         end
         last_p = P;
      end else begin
         chk("p_hold", 32'(P), 32'(last_p));
      end
   end

   // Called on a falling edge; returns on the falling edge after the accepting rising edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] m);
      A     = a;
      M     = m;
      start = 1'b1;
      exp_q.push_back(model(a, m));
      @(negedge clk);
      start = 1'b0;
      chk("busy_run", 32'(busy), 32'(1));
   endtask

   // Returns on the falling edge inside the done cycle, so a back-to-back start can follow.
   task automatic wait_done(input int exp_lat);
      int lat;
      lat = 0;
      while (!done && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         chk("done_timeout", 32'(0), 32'(1));
      end else if (exp_lat > 0) begin
         chk("latency", 32'(lat), 32'(exp_lat));
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      last_p = '0;
      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      M     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // directed vectors
      issue(4'b1101, 4'b1011); wait_done(W + 1);
      issue(4'b1001, 4'b0001); wait_done(W + 1);
      issue(4'b0111, 4'b1111); wait_done(W + 1);
      issue(4'b1010, 4'b0010); wait_done(W + 1);
      issue(4'b1000, 4'b1000); wait_done(W + 1);

      // exhaustive, back-to-back
      for (int a = 0; a < (1 << W); a++) begin
         for (int m = 0; m < (1 << W); m++) begin
            issue(W'(a), W'(m));
            wait_done(W + 1);
         end
      end
      @(negedge clk);
      chk("done_width", 32'(done), 32'(0));

      // operand change and start during RUN are ignored
      issue(4'b0110, 4'b1101);
      @(negedge clk);
      A = 4'b1111; M = 4'b0111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(0);
      @(negedge clk);
      repeat (8) @(negedge clk);
      chk("no_extra_op", 32'(exp_q.size()), 32'(0));

      // reset during RUN cycle 2
      issue(4'b0101, 4'b0011);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("no_done_after_rst", 32'(done), 32'(0));
      issue(4'b1011, 4'b0110); wait_done(W + 1);
      @(negedge clk);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
